// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator turning byte-addressed loads/stores into word-index memory accesses.
// Latency: loads, word stores and faulted requests take 1 cycle; sub-word stores take 2 (read, then merged write).
// Backpressure: stall is high during the read cycle of a sub-word store; request inputs must be held until it drops.
module mem_access_unit #(
   parameter int MEM_WORDS = 100
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        fault,
   output logic        fault_sticky,
   output logic [15:0] rmw_count,
   output logic [31:0] mem_A,
   output logic [31:0] mem_WD,
   output logic        mem_WE,
   input  logic [31:0] mem_RD
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } state_t;

   localparam logic [31:0] WORD_LIMIT = MEM_WORDS;

   state_t      state_q, state_d;
   logic [31:0] merge_q, merge_d;
   logic [29:0] idx_q, idx_d;
   logic [15:0] rmw_count_q, rmw_count_d;
   logic        sticky_q, sticky_d;

   logic        req_any;
   logic        is_store;
   logic        is_byte;
   logic        is_half;
   logic        is_word;
   logic [29:0] word_idx;
   logic        misaligned;
   logic        out_of_range;
   logic        req_fault;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_val;
   logic [31:0] store_merge;
   logic        we_raw;

   // Request decode: store wins over load, size 11 behaves as a word, and fault detection.
   always_comb begin
      req_any      = req_read | req_write;
      is_store     = req_write;
      is_byte      = (size == 2'b00);
      is_half      = (size == 2'b01);
      is_word      = size[1];
      word_idx     = addr[31:2];
      misaligned   = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
      out_of_range = ({2'b00, word_idx} >= WORD_LIMIT);
      req_fault    = req_any & (misaligned | out_of_range);
   end

   // Lane handling: extract/extend the addressed lane for loads, splice store data into the read word.
   always_comb begin
      lane_b = mem_RD[7:0];
      case (addr[1:0])
         2'd0: lane_b = mem_RD[7:0];
         2'd1: lane_b = mem_RD[15:8];
         2'd2: lane_b = mem_RD[23:16];
         2'd3: lane_b = mem_RD[31:24];
      endcase
      lane_h = addr[1] ? mem_RD[31:16] : mem_RD[15:0];

      if (is_byte) begin
         load_val = {{24{sign_ext & lane_b[7]}}, lane_b};
      end else if (is_half) begin
         load_val = {{16{sign_ext & lane_h[15]}}, lane_h};
      end else begin
         load_val = mem_RD;
      end

      store_merge = mem_RD;
      if (is_byte) begin
         case (addr[1:0])
            2'd0: store_merge[7:0]   = wdata[7:0];
            2'd1: store_merge[15:8]  = wdata[7:0];
            2'd2: store_merge[23:16] = wdata[7:0];
            2'd3: store_merge[31:24] = wdata[7:0];
         endcase
      end else if (is_half) begin
         if (addr[1]) begin
            store_merge[31:16] = wdata[15:0];
         end else begin
            store_merge[15:0] = wdata[15:0];
         end
      end
   end

   // FSM next state and memory-port outputs; request inputs only matter in IDLE.
   always_comb begin
      state_d     = state_q;
      merge_d     = merge_q;
      idx_d       = idx_q;
      rmw_count_d = rmw_count_q;
      sticky_d    = sticky_q;
      rdata       = 32'h0;
      stall       = 1'b0;
      fault       = 1'b0;
      mem_A       = 32'h0;
      mem_WD      = 32'h0;
      we_raw      = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_any) begin
               mem_A = {2'b00, word_idx};
               if (req_fault) begin
                  // Faulted requests are dropped entirely: no write, no data, no RMW.
                  fault    = 1'b1;
                  sticky_d = 1'b1;
               end else if (is_store) begin
                  if (is_word) begin
                     we_raw = 1'b1;
                     mem_WD = wdata;
                  end else begin
                     // Read phase: capture the merged word now, write it next cycle.
                     stall   = 1'b1;
                     merge_d = store_merge;
                     idx_d   = word_idx;
                     state_d = RMW_WR;
                  end
               end else begin
                  rdata = load_val;
               end
            end
         end
         RMW_WR: begin
            // Pipeline advances at this edge, so the held store retires exactly once.
            mem_A       = {2'b00, idx_q};
            mem_WD      = merge_q;
            we_raw      = 1'b1;
            rmw_count_d = rmw_count_q + 16'd1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Write enable is masked by reset so an interrupted RMW never writes a partial result.
   always_comb begin
      mem_WE       = we_raw & reset;
      fault_sticky = sticky_q;
      rmw_count    = rmw_count_q;
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         merge_q     <= 32'h0;
         idx_q       <= 30'h0;
         rmw_count_q <= 16'h0;
         sticky_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         merge_q     <= merge_d;
         idx_q       <= idx_d;
         rmw_count_q <= rmw_count_d;
         sticky_q    <= sticky_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table, hand-written reset/RMW sequences and a randomized run
// checked against a byte-array reference of the data memory.
// The attached memory is modelled here with a combinational read and a clocked write.
module tb_mem_access_unit;

   logic        CLK;
   logic        reset;
   logic        req_read;
   logic        req_write;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        fault;
   logic        fault_sticky;
   logic [15:0] rmw_count;
   logic [31:0] mem_A;
   logic [31:0] mem_WD;
   logic        mem_WE;
   logic [31:0] mem_RD;

   // Memory model plus a backdoor load port used only while the DUT is quiet.
   logic [31:0] mem [0:99];
   logic        bd_we;
   logic [6:0]  bd_idx;
   logic [31:0] bd_dat;

   int n_pass;
   int n_total;

   mem_access_unit #(.MEM_WORDS(100)) dut (
      .CLK          (CLK),
      .reset        (reset),
      .req_read     (req_read),
      .req_write    (req_write),
      .size         (size),
      .sign_ext     (sign_ext),
      .addr         (addr),
      .wdata        (wdata),
      .rdata        (rdata),
      .stall        (stall),
      .fault        (fault),
      .fault_sticky (fault_sticky),
      .rmw_count    (rmw_count),
      .mem_A        (mem_A),
      .mem_WD       (mem_WD),
      .mem_WE       (mem_WE),
      .mem_RD       (mem_RD)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   assign mem_RD = (mem_A < 32'd100) ? mem[mem_A[6:0]] : 32'h0;

   always @(posedge CLK) begin
      if (bd_we) begin
         mem[bd_idx] <= bd_dat;
      end else if (mem_WE && (mem_A < 32'd100)) begin
         mem[mem_A[6:0]] <= mem_WD;
      end
   end

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  sz;
      logic        sx;
      logic [31:0] a;
      logic [31:0] wd;
      logic        e_st;
      logic        e_flt;
      logic        e_we;
      logic [31:0] e_rd;
   } vec_t;

   function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                               input logic [31:0] a, input logic [31:0] wd, input logic e_st,
                               input logic e_flt, input logic e_we, input logic [31:0] e_rd);
      vec_t v;
      v.rd = rd; v.wr = wr; v.sz = sz; v.sx = sx; v.a = a; v.wd = wd;
      v.e_st = e_st; v.e_flt = e_flt; v.e_we = e_we; v.e_rd = e_rd;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic check1(input string nm, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", nm, act, exp);
   endtask

   task automatic bd_write(input int idx, input logic [31:0] dat);
      bd_idx = 7'(idx);
      bd_dat = dat;
      bd_we  = 1'b1;
      @(posedge CLK);
      #1;
      bd_we  = 1'b0;
   endtask

   // Called 1 time unit after a rising edge; returns at the same phase once the access retires.
   task automatic do_op(input string nm, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] wd,
                        input logic e_st, input logic e_flt, input logic e_we, input logic [31:0] e_rd);
      logic [31:0] e_a;
      req_read  = rd;
      req_write = wr;
      size      = sz;
      sign_ext  = sx;
      addr      = a;
      wdata     = wd;
      e_a = (rd | wr) ? {2'b00, a[31:2]} : 32'h0;
      @(negedge CLK);
      check1({nm, " stall"}, stall, e_st);
      check1({nm, " fault"}, fault, e_flt);
      check1({nm, " mem_WE"}, mem_WE, e_we);
      check({nm, " rdata"}, rdata, e_rd);
      check({nm, " mem_A"}, mem_A, e_a);
      if (e_we) check({nm, " mem_WD"}, mem_WD, wd);
      @(posedge CLK);
      #1;
      if (e_st) begin
         @(negedge CLK);
         check1({nm, " wr-phase stall"}, stall, 1'b0);
         check1({nm, " wr-phase mem_WE"}, mem_WE, 1'b1);
         check({nm, " wr-phase mem_A"}, mem_A, e_a);
         @(posedge CLK);
         #1;
      end
      req_read  = 1'b0;
      req_write = 1'b0;
   endtask

   vec_t vecs [26];

   // Reference: byte-granular memory and counters derived directly from the access rules.
   logic [7:0]  rbytes [int];
   int          ref_rmw;
   logic        ref_sticky;

   int          t, r, nb;
   logic        rd, wr, sx, flt, e_st, e_we;
   logic [1:0]  sz;
   logic [31:0] a, wd, v, e_rd;

   initial begin
      n_pass = 0;
      n_total = 0;
      reset = 1'b0;
      req_read = 1'b0; req_write = 1'b0; size = 2'b00; sign_ext = 1'b0;
      addr = 32'h0; wdata = 32'h0;
      bd_we = 1'b0; bd_idx = 7'h0; bd_dat = 32'h0;

      // Reset values with no request.
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst rdata", rdata, 32'h0);
      check1("rst stall", stall, 1'b0);
      check1("rst fault", fault, 1'b0);
      check1("rst fault_sticky", fault_sticky, 1'b0);
      check("rst rmw_count", 32'(rmw_count), 32'h0);
      check("rst mem_A", mem_A, 32'h0);
      check("rst mem_WD", mem_WD, 32'h0);
      check1("rst mem_WE", mem_WE, 1'b0);
      @(posedge CLK);
      #1;

      for (int i = 0; i < 100; i++) bd_write(i, 32'h0);
      bd_write(3, 32'h11223344);
      reset = 1'b1;
      @(negedge CLK);
      check1("post-rst stall", stall, 1'b0);
      check("post-rst rmw_count", 32'(rmw_count), 32'h0);
      @(posedge CLK);
      #1;

      //                rd    wr    sz     sx    addr          wdata         st    flt   we    rdata
      vecs[0]  = mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0008, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h0);
      vecs[1]  = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
      vecs[2]  = mk(1'b1, 1'b0, 2'd3, 1'b1, 32'h0000_0008, 32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
      vecs[3]  = mk(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_000D, 32'hFFFFFFAA, 1'b1, 1'b0, 1'b0, 32'h0);
      vecs[4]  = mk(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_000D, 32'h0,        1'b0, 1'b0, 1'b0, 32'hFFFFFFAA);
      vecs[5]  = mk(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_000D, 32'h0,        1'b0, 1'b0, 1'b0, 32'h000000AA);
      vecs[6]  = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'h0,        1'b0, 1'b0, 1'b0, 32'h1122AA44);
      vecs[7]  = mk(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_000F, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00000011);
      vecs[8]  = mk(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'h12348001, 1'b1, 1'b0, 1'b0, 32'h0);
      vecs[9]  = mk(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0,        1'b0, 1'b0, 1'b0, 32'hFFFF8001);
      vecs[10] = mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00008001);
      vecs[11] = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 1'b0, 1'b0, 32'h80010000);
      vecs[12] = mk(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00000000);
      vecs[13] = mk(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0,        1'b0, 1'b0, 1'b0, 32'hFFFFFF80);
      vecs[14] = mk(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0005, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0);
      vecs[15] = mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0190, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0);
      vecs[16] = mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0009, 32'h01020304, 1'b0, 1'b1, 1'b0, 32'h0);
      vecs[17] = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0190, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0);
      vecs[18] = mk(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0020, 32'h00000011, 1'b1, 1'b0, 1'b0, 32'h0);
      vecs[19] = mk(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0021, 32'h00000022, 1'b1, 1'b0, 1'b0, 32'h0);
      vecs[20] = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00002211);
      vecs[21] = mk(1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0024, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b1, 32'h0);
      vecs[22] = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0024, 32'h0,        1'b0, 1'b0, 1'b0, 32'h5A5A5A5A);
      vecs[23] = mk(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0044, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0);
      vecs[24] = mk(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0190, 32'h000000EE, 1'b0, 1'b1, 1'b0, 32'h0);
      vecs[25] = mk(1'b0, 1'b1, 2'd1, 1'b0, 32'hFFFF_FFF0, 32'h0000BEEF, 1'b0, 1'b1, 1'b0, 32'h0);

      for (int i = 0; i < 26; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].sx,
               vecs[i].a, vecs[i].wd, vecs[i].e_st, vecs[i].e_flt, vecs[i].e_we, vecs[i].e_rd);
      end
      check("table rmw_count", 32'(rmw_count), 32'd4);
      check1("table fault_sticky", fault_sticky, 1'b1);
      check("table word3", mem[3], 32'h1122AA44);
      check("table word4", mem[4], 32'h80010000);

      // Reset dropped during the write phase of an RMW.
      bd_write(5, 32'hCAFEF00D);
      req_read = 1'b0; req_write = 1'b1; size = 2'd0; sign_ext = 1'b0;
      addr = 32'h0000_0014; wdata = 32'h00000077;
      @(negedge CLK);
      check1("midrst read-phase stall", stall, 1'b1);
      @(posedge CLK);
      #1;
      check1("midrst write-phase mem_WE", mem_WE, 1'b1);
      reset = 1'b0;
      req_write = 1'b0;
      #1;
      check1("midrst mem_WE", mem_WE, 1'b0);
      check("midrst rmw_count", 32'(rmw_count), 32'h0);
      check1("midrst fault_sticky", fault_sticky, 1'b0);
      @(posedge CLK);
      #1;
      reset = 1'b1;
      @(negedge CLK);
      check("midrst word5", mem[5], 32'hCAFEF00D);
      @(posedge CLK);
      #1;
      do_op("midrst lw", 1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D);
      do_op("midrst sb", 1'b0, 1'b1, 2'd0, 1'b0, 32'h14, 32'h77, 1'b1, 1'b0, 1'b0, 32'h0);
      check("midrst rmw after", 32'(rmw_count), 32'd1);
      do_op("midrst lw2", 1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 1'b0, 32'hCAFEF077);

      // Randomized run against the byte-array reference.
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         v = $urandom;
         bd_write(i, v);
         for (int k = 0; k < 4; k++) rbytes[4 * i + k] = v[8 * k +: 8];
      end
      reset = 1'b1;
      ref_rmw = 0;
      ref_sticky = 1'b0;
      check1("rnd start fault_sticky", fault_sticky, 1'b0);
      for (int n = 0; n < 400; n++) begin
         t  = int'($urandom_range(0, 9));
         rd = (t == 1) || (t >= 2 && t <= 5);
         wr = (t == 1) || (t >= 6);
         sz = 2'($urandom_range(0, 3));
         sx = 1'($urandom_range(0, 1));
         r  = int'($urandom_range(0, 9));
         if (r == 0) a = $urandom;
         else if (r == 1) a = $urandom_range(400, 440);
         else a = $urandom_range(0, 399);
         nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
         if ($urandom_range(0, 1) == 1) a = a & ~32'(nb - 1);
         wd = $urandom;
         flt  = (rd || wr) && (((a % 32'(nb)) != 32'd0) || ((a >> 2) >= 32'd100));
         e_st = 1'b0;
         e_we = 1'b0;
         e_rd = 32'h0;
         if (flt) begin
            ref_sticky = 1'b1;
         end else if (wr) begin
            for (int k = 0; k < nb; k++) rbytes[int'(a) + k] = wd[8 * k +: 8];
            if (nb < 4) begin
               e_st = 1'b1;
               ref_rmw++;
            end else begin
               e_we = 1'b1;
            end
         end else if (rd) begin
            v = 32'h0;
            for (int k = 0; k < nb; k++) v[8 * k +: 8] = rbytes[int'(a) + k];
            if (sx && nb < 4 && v[8 * nb - 1]) begin
               for (int k = nb; k < 4; k++) v[8 * k +: 8] = 8'hFF;
            end
            e_rd = v;
         end
         do_op($sformatf("rnd%0d", n), rd, wr, sz, sx, a, wd, e_st, flt, e_we, e_rd);
      end
      for (int i = 0; i < 100; i++) begin
         check($sformatf("rnd mem[%0d]", i), mem[7'(i)],
               {rbytes[4 * i + 3], rbytes[4 * i + 2], rbytes[4 * i + 1], rbytes[4 * i]});
      end
      check("rnd rmw_count", 32'(rmw_count), 32'(ref_rmw));
      check1("rnd fault_sticky", fault_sticky, ref_sticky);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Pipeline-side initiator for the word-indexed data memory. It sits in the MEM stage.
- Converts byte-addressed MIPS loads and stores (lw/lh/lhu/lb/lbu, sw/sh/sb) into word-index accesses on the memory port.
- Sub-word stores run as a 2-cycle read-modify-write; `stall` is asserted while one is in progress.
- Detects misaligned and out-of-range accesses, suppresses them and records them.

Parameters:
- MEM_WORDS, 100, number of 32-bit words in the attached data memory; valid word index is 0..MEM_WORDS-1.

Ports:
- CLK  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_read  input  1  load request from the MEM stage.
- req_write  input  1  store request from the MEM stage; has priority if both request inputs are high.
- size  input  2  access size: 00 byte, 01 halfword, 10 word; 11 is treated as word.
- sign_ext  input  1  for loads: 1 sign-extends, 0 zero-extends.
- addr  input  32  byte address.
- wdata  input  32  store data; the lower bytes are used for sub-word stores.
- rdata  output  32  aligned and extended load result (combinational).
- stall  output  1  pipeline must hold all request inputs stable while this is 1.
- fault  output  1  the current request is misaligned or out of range (combinational).
- fault_sticky  output  1  set by any fault; cleared only by reset.
- rmw_count  output  16  count of completed sub-word stores; wraps from 0xFFFF to 0.
- mem_A  output  32  word index to memory, = addr[31:2] zero-extended.
- mem_WD  output  32  write data to memory.
- mem_WE  output  1  write enable to memory.
- mem_RD  input  32  combinational read data from memory.

Behaviour:
- Memory contract: read is combinational (`mem_RD` = word at `mem_A`); write occurs at the rising edge of `CLK` when `mem_WE`=1.
- Byte ordering is little-endian: byte k of a word (k = `addr[1:0]`) is bits [8k+7:8k]. Halfword h (h = `addr[1]`) is bits [16h+15:16h].
- Fault conditions:
  - halfword access with `addr[0]`=1;
  - word access with `addr[1:0]`≠0;
  - `addr[31:2]` ≥ MEM_WORDS.
- On a fault: `fault`=1, `mem_WE`=0, `rdata`=0, `stall`=0, and `fault_sticky` is set at the next edge. There is no RMW.
- States: IDLE, RMW_WR.
- IDLE behaviour:
  - No request: `mem_WE`=0, `stall`=0, `rdata`=0, `mem_WD`=0.
  - Load: single cycle. `rdata` = selected lane of `mem_RD`, extended according to `sign_ext`; a word load passes through unchanged. `stall`=0.
  - Word store: single cycle. `mem_WE`=1, `mem_WD`=`wdata`, `stall`=0.
  - Sub-word store: `mem_WE`=0 and `stall`=1. Latch a merged word into `merge_q`: `mem_RD` with the target lane replaced by `wdata[7:0]` or `wdata[15:0]`. Latch the word index into `idx_q`. Go to RMW_WR.
- RMW_WR behaviour:
  - `mem_A`=`idx_q`, `mem_WE`=1, `mem_WD`=`merge_q`, `stall`=0.
  - At the edge: increment `rmw_count` and return to IDLE.
  - The pipeline advances at this edge, so the held store completes exactly once.
- Latency:
  - loads, word stores and faulted requests: 1 cycle;
  - sub-word stores: 2 cycles, with 1 stall cycle.
- Request inputs are ignored in RMW_WR; their held values are used only in IDLE.
- Back-to-back sub-word stores: the IDLE read phase of the second store follows the first store's write. The second store therefore sees the updated word, including when both target the same word.
- Reset asserted at any time, including mid-RMW:
  - state goes to IDLE immediately;
  - `merge_q`=0, `idx_q`=0, `rmw_count`=0, `fault_sticky`=0;
  - `mem_WE` goes low combinationally, so no partial write occurs.
- Reset values of outputs with no request present: `rdata`=0, `stall`=0, `fault`=0, `fault_sticky`=0, `rmw_count`=0, `mem_A`=0, `mem_WD`=0, `mem_WE`=0.

Test Plan:
- Word store then load: sw 0xDEADBEEF to addr 0x8, then lw from 0x8 → `mem_A`=2, `mem_WE` high for 1 cycle, `rdata`=0xDEADBEEF, `stall` never asserted.
- Byte RMW: word 3 = 0x11223344, then sb 0xAA to addr 0xD → `stall` for 1 cycle, word 3 = 0x1122AA44, `rmw_count`=1. Then lb from 0xD → 0xFFFFFFAA; lbu from 0xD → 0x000000AA.
- Halfword: sh 0x8001 to addr 0x12 over word 4 = 0 → word 4 = 0x80010000. lh from 0x12 → 0xFFFF8001; lhu → 0x00008001.
- Faults: lh from 0x5 → `fault`=1, `rdata`=0. sw to addr 0x190 (index 100) → `mem_WE` stays 0 and memory is unchanged. `fault_sticky` is 1 after either and remains set until reset.
- Back-to-back: sb 0x11 to 0x20, then sb 0x22 to 0x21 → word 8 = 0x00002211, 4 total cycles, `rmw_count`=2.
- Reset mid-RMW: drop `reset` during RMW_WR → `mem_WE`=0 immediately, target word unchanged, `rmw_count`=0, state is IDLE after release.
